// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the multi-cycle divider sequencer.
// State encoding and handshake levels used by div_ctrl and its step datapath.
package div_ctrl_pkg;

    localparam int DIV_DW = 32;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_ctrl_step.sv
// One radix-2 restoring division step: shifts {rem,quo} left by one and
// subtracts the divisor from the widened partial remainder when it fits.
module div_ctrl_step #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rem,
    input  logic [DW-1:0] quo,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] rem_nxt,
    output logic [DW-1:0] quo_nxt
);

    logic [DW:0]   partial_s;
    logic [DW+1:0] trial_s;
    logic          unused_s;

    // The DW+1-bit partial keeps unsigned divisors up to 2^DW-1 exact.
    always_comb begin
        partial_s = {rem, quo[DW-1]};
        trial_s   = {1'b0, partial_s} - {2'b00, divisor};
        if (trial_s[DW+1] == 1'b0) begin
            rem_nxt = trial_s[DW-1:0];
            quo_nxt = {quo[DW-2:0], 1'b1};
        end else begin
            rem_nxt = partial_s[DW-1:0];
            quo_nxt = {quo[DW-2:0], 1'b0};
        end
    end

    assign unused_s = trial_s[DW] ^ partial_s[DW];

endmodule

// File: rtl/div_ctrl.sv
// Sequencer for the shared multi-cycle divider (DIV/DIVU): operand latching,
// 32 restoring steps, MIPS sign fix-up and pipeline stall request.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DW = DIV_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            signed_div_i,
    input  logic [DW-1:0]   opdata1_i,
    input  logic [DW-1:0]   opdata2_i,
    input  logic            start_i,
    input  logic            annul_i,
    output logic [2*DW-1:0] result_o,
    output logic            ready_o,
    output logic            stallreq_o
);

    localparam int CW = $clog2(DW) + 1;

    div_state_e      state_r, state_nxt_s;
    logic [CW-1:0]   cnt_r, cnt_nxt_s;
    logic            sign1_r, sign1_nxt_s, sign2_r, sign2_nxt_s;
    logic [DW-1:0]   divisor_r, divisor_nxt_s;
    logic [DW-1:0]   rem_r, rem_nxt_s, quo_r, quo_nxt_s;
    logic [DW-1:0]   rem_step_s, quo_step_s;
    logic [2*DW-1:0] result_r, result_nxt_s;
    logic            ready_r, ready_nxt_s;
    logic            accept_s;
    logic            neg1_s, neg2_s;

    div_ctrl_step #(.DW(DW)) u_step (
        .rem     (rem_r),
        .quo     (quo_r),
        .divisor (divisor_r),
        .rem_nxt (rem_step_s),
        .quo_nxt (quo_step_s)
    );

    assign accept_s   = (start_i == DIV_START) && !annul_i;
    assign neg1_s     = signed_div_i && opdata1_i[DW-1];
    assign neg2_s     = signed_div_i && opdata2_i[DW-1];
    assign stallreq_o = ((state_r == DIV_FREE) && accept_s) ||
                        (state_r == DIV_ON) || (state_r == DIV_BYZERO);
    assign result_o   = result_r;
    assign ready_o    = ready_r;

    // Next-state, datapath and output computation.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        sign1_nxt_s   = sign1_r;
        sign2_nxt_s   = sign2_r;
        divisor_nxt_s = divisor_r;
        rem_nxt_s     = rem_r;
        quo_nxt_s     = quo_r;
        result_nxt_s  = result_r;
        ready_nxt_s   = ready_r;
        case (state_r)
            DIV_FREE: begin
                ready_nxt_s  = DIV_RESULT_NOT_READY;
                result_nxt_s = {(2*DW){1'b0}};
                if (accept_s) begin
                    if (opdata2_i == {DW{1'b0}}) begin
                        state_nxt_s = DIV_BYZERO;
                    end else begin
                        state_nxt_s   = DIV_ON;
                        cnt_nxt_s     = {CW{1'b0}};
                        sign1_nxt_s   = neg1_s;
                        sign2_nxt_s   = neg2_s;
                        divisor_nxt_s = neg2_s ? ({DW{1'b0}} - opdata2_i) : opdata2_i;
                        rem_nxt_s     = {DW{1'b0}};
                        quo_nxt_s     = neg1_s ? ({DW{1'b0}} - opdata1_i) : opdata1_i;
                    end
                end else begin
                    state_nxt_s = DIV_FREE;
                end
            end
            DIV_BYZERO: begin
                state_nxt_s  = DIV_END;
                result_nxt_s = {(2*DW){1'b0}};
                ready_nxt_s  = DIV_RESULT_READY;
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_nxt_s  = DIV_FREE;
                    cnt_nxt_s    = {CW{1'b0}};
                    ready_nxt_s  = DIV_RESULT_NOT_READY;
                    result_nxt_s = {(2*DW){1'b0}};
                end else if (cnt_r != CW'(DW)) begin
                    rem_nxt_s = rem_step_s;
                    quo_nxt_s = quo_step_s;
                    cnt_nxt_s = cnt_r + CW'(1);
                end else begin
                    // MIPS: quotient sign is sign1^sign2, remainder follows the dividend.
                    result_nxt_s = {sign1_r ? ({DW{1'b0}} - rem_r) : rem_r,
                                    (sign1_r ^ sign2_r) ? ({DW{1'b0}} - quo_r) : quo_r};
                    ready_nxt_s  = DIV_RESULT_READY;
                    state_nxt_s  = DIV_END;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_nxt_s  = DIV_FREE;
                    ready_nxt_s  = DIV_RESULT_NOT_READY;
                    result_nxt_s = {(2*DW){1'b0}};
                end else begin
                    state_nxt_s = DIV_END;
                end
            end
            default: begin
                state_nxt_s  = DIV_FREE;
                cnt_nxt_s    = {CW{1'b0}};
                ready_nxt_s  = DIV_RESULT_NOT_READY;
                result_nxt_s = {(2*DW){1'b0}};
            end
        endcase
    end

    // State, counter, operand latches and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= DIV_FREE;
            cnt_r     <= {CW{1'b0}};
            sign1_r   <= 1'b0;
            sign2_r   <= 1'b0;
            divisor_r <= {DW{1'b0}};
            rem_r     <= {DW{1'b0}};
            quo_r     <= {DW{1'b0}};
            result_r  <= {(2*DW){1'b0}};
            ready_r   <= DIV_RESULT_NOT_READY;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            sign1_r   <= sign1_nxt_s;
            sign2_r   <= sign2_nxt_s;
            divisor_r <= divisor_nxt_s;
            rem_r     <= rem_nxt_s;
            quo_r     <= quo_nxt_s;
            result_r  <= result_nxt_s;
            ready_r   <= ready_nxt_s;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: signed/unsigned results, latency, stall,
// divide-by-zero, overflow, annul and asynchronous reset behaviour.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1, op2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready, stall;

    int total = 0;
    int bad   = 0;

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .stallreq_o   (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start a division with start held, count edges to ready and stall cycles,
    // then check hold behaviour in DIV_END and the clear on start release.
    task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int exp_edges);
        int edges;
        int stalls;
        signed_div = sg;
        op1 = a;
        op2 = b;
        annul = 1'b0;
        start = 1'b1;
        #1;
        check({tag, "_stall_req"}, 64'(stall), 64'd1);
        edges = 0;
        stalls = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (!ready && stall) stalls++;
            op1 = a ^ 32'h5A5A_A5A5;
            op2 = b + 32'd3;
        end while (!ready && edges < 60);
        check({tag, "_edges"}, 64'(edges), 64'(exp_edges));
        check({tag, "_stalls"}, 64'(stalls), 64'(exp_edges - 1));
        check({tag, "_result"}, result, exp);
        check({tag, "_stall_end"}, 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_hold_ready"}, 64'(ready), 64'd1);
        check({tag, "_hold_result"}, result, exp);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_clr_ready"}, 64'(ready), 64'd0);
        check({tag, "_clr_result"}, result, 64'd0);
    endtask

    initial begin
        int edges;
        int seen;
        rst = 1'b1;
        signed_div = 1'b0;
        op1 = 32'd0;
        op2 = 32'd0;
        start = 1'b0;
        annul = 1'b0;
        #2;
        check("rst_result", result, 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 34);
        run_div("div_5_0", 1'b1, 32'd5, 32'd0, 64'd0, 2);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34);
        run_div("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 34);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 34);

        // Annul at step 10: back to FREE on the next edge, no result.
        signed_div = 1'b0;
        op1 = 32'd100;
        op2 = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        #1;
        check("annul_stall_on", 64'(stall), 64'd1);
        @(posedge clk);
        #1;
        check("annul_stall_free", 64'(stall), 64'd0);
        check("annul_ready", 64'(ready), 64'd0);
        annul = 1'b0;
        start = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) seen++;
        end
        check("annul_never_ready", 64'(seen), 64'd0);
        run_div("after_annul", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 34);

        // Asynchronous reset in the middle of the step sequence.
        signed_div = 1'b0;
        op1 = 32'd1000;
        op2 = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        start = 1'b0;
        #1;
        check("rst_on_ready", 64'(ready), 64'd0);
        check("rst_on_result", result, 64'd0);
        check("rst_on_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_div("after_rst_on", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 34);

        // Asynchronous reset while a finished result is being held.
        signed_div = 1'b0;
        op1 = 32'd50;
        op2 = 32'd8;
        start = 1'b1;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!ready && edges < 60);
        check("end_result", result, {32'd2, 32'd6});
        #2;
        rst = 1'b1;
        #1;
        check("rst_end_ready", 64'(ready), 64'd0);
        check("rst_end_result", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
